// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector.
// Watches a valid-qualified bit stream for a loadable pattern of 2..MAX_LEN
// bits and reports each hit three ways: a same-cycle Mealy pulse, a
// registered copy one cycle later, and a saturating hit counter.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenMin = LEN_W'(2);

  state_t               r_state;
  state_t               w_nextState;
  logic [MAX_LEN-1:0]   r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic                 r_overlap;
  logic [MAX_LEN-1:0]   r_history;
  logic [LEN_W-1:0]     r_fill;
  logic                 r_matchQ;
  logic [CNT_W-1:0]     r_matchCnt;
  logic                 r_cfgErr;

  logic                 w_cfgLegal;
  logic                 w_accept;
  logic                 w_fillOk;
  logic                 w_patHit;
  logic                 w_match;
  logic                 w_armed;
  logic [MAX_LEN-1:0]   w_nextHist;
  logic [MAX_LEN-1:0]   w_mask;

  assign w_cfgLegal = (cfg_len >= LenMin) && (cfg_len <= LenMax);
  assign w_accept   = in_valid & ~cfg_we & (r_state == RUN);
  assign w_nextHist = {r_history[MAX_LEN-2:0], in};
  // One more bit (the current one) must complete at least len bits of history.
  assign w_fillOk   = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_patHit   = ((w_nextHist ^ r_pattern) & w_mask) == '0;

  // Build a mask selecting the low r_len bits of history and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  // State register: only reset returns the detector to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state, armed flag and the combinational Mealy match.
  always_comb begin
    w_nextState = r_state;
    w_armed     = 1'b0;
    w_match     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_we && w_cfgLegal) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_armed = 1'b1;
        w_match = w_accept & w_fillOk & w_patHit;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Configuration, history shifting, fill tracking, delayed match and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern  <= '0;
      r_len      <= '0;
      r_overlap  <= 1'b0;
      r_history  <= '0;
      r_fill     <= '0;
      r_matchQ   <= 1'b0;
      r_matchCnt <= '0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_matchQ <= w_match;
      r_cfgErr <= cfg_we & ~w_cfgLegal;

      if (cnt_clr) begin
        r_matchCnt <= '0;
      end else if (w_match && (r_matchCnt != {CNT_W{1'b1}})) begin
        r_matchCnt <= r_matchCnt + CNT_W'(1);
      end

      if (cfg_we && w_cfgLegal) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_history <= '0;
        r_fill    <= '0;
      end else if (w_accept) begin
        r_history <= w_nextHist;
        if (w_match && !r_overlap) begin
          r_fill <= '0;
        end else if (r_fill != LenMax) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end
    end
  end

  assign match     = w_match;
  assign match_q   = r_matchQ;
  assign match_cnt = r_matchCnt;
  assign cfg_err   = r_cfgErr;
  assign armed     = w_armed;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a queue-based reference model of
// the detector predicts every cycle's outputs, a monitor compares them.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_clr;
  logic               cfg_err;
  logic               armed;

  typedef struct {
    logic             m;
    logic             mq;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             arm;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   pushed      = 0;
  int   popped      = 0;

  // Reference model state: the bits accepted since the last (re)start,
  // oldest first, plus the loaded configuration and registered outputs.
  bit               mRun;
  bit [MAX_LEN-1:0] mPat;
  int               mLen;
  bit               mOv;
  bit               mBits[$];
  bit               mMq;
  int               mCnt;
  bit               mErr;

  seq_detect_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .in         (in),
    .match      (match),
    .match_q    (match_q),
    .match_cnt  (match_cnt),
    .cnt_clr    (cnt_clr),
    .cfg_err    (cfg_err),
    .armed      (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic applyStimulus(input bit iRst, input bit iWe, input bit [MAX_LEN-1:0] iPat,
                               input int iLen, input bit iOv, input bit iV, input bit iB,
                               input bit iClr);
    exp_t e;
    bit   hit;
    bit   bk;
    @(posedge clk);
    #1;
    rst         = iRst;
    cfg_we      = iWe;
    cfg_pattern = iPat;
    cfg_len     = LEN_W'(iLen);
    cfg_overlap = iOv;
    in_valid    = iV;
    in          = iB;
    cnt_clr     = iClr;

    hit = 1'b0;
    if (mRun && iV && !iWe && (mBits.size() + 1 >= mLen)) begin
      hit = 1'b1;
      for (int k = 0; k < mLen; k++) begin
        bk = (k == 0) ? iB : mBits[mBits.size() - k];
        if (bk != mPat[k]) hit = 1'b0;
      end
    end
    e.m   = hit;
    e.mq  = mMq;
    e.cnt = CNT_W'(mCnt);
    e.err = mErr;
    e.arm = mRun;
    expQ.push_back(e);
    pushed++;

    if (iRst) begin
      mRun = 0; mPat = '0; mLen = 0; mOv = 0; mMq = 0; mCnt = 0; mErr = 0;
      mBits.delete();
    end else begin
      mMq = hit;
      if (iClr) mCnt = 0;
      else if (hit && mCnt < (1 << CNT_W) - 1) mCnt++;
      mErr = iWe && !(iLen >= 2 && iLen <= MAX_LEN);
      if (iWe && iLen >= 2 && iLen <= MAX_LEN) begin
        mRun = 1; mPat = iPat; mLen = iLen; mOv = iOv;
        mBits.delete();
      end else if (mRun && iV && !iWe) begin
        if (hit && !mOv) begin
          mBits.delete();
        end else begin
          mBits.push_back(iB);
          if (mBits.size() > MAX_LEN) void'(mBits.pop_front());
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic sendBits(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(0, 0, '0, 0, 0, 1, s[i] == "1", 0);
  endtask

  task automatic configure(input bit [MAX_LEN-1:0] pat, input int len, input bit ov);
    applyStimulus(0, 1, pat, len, ov, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare them with the
  // oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        popped++;
        checkOutput("match",     32'(match),     32'(e.m));
        checkOutput("match_q",   32'(match_q),   32'(e.mq));
        checkOutput("match_cnt", 32'(match_cnt), 32'(e.cnt));
        checkOutput("cfg_err",   32'(cfg_err),   32'(e.err));
        checkOutput("armed",     32'(armed),     32'(e.arm));
      end
    end
  end

  initial begin
    int r;
    rst = 1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; in = 0; cnt_clr = 0;
    mRun = 0; mPat = '0; mLen = 0; mOv = 0; mMq = 0; mCnt = 0; mErr = 0;
    repeat (2) @(posedge clk);
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("reset_armed", 32'(armed), 32'd0);
    checkOutput("reset_cnt", 32'(match_cnt), 32'd0);

    // Overlapping detection of 11011
    configure(8'b0001_1011, 5, 1);
    sendBits("1101101111011");
    idle(1);
    checkOutput("overlap_cnt", 32'(match_cnt), 32'd3);

    // Non-overlapping detection on the same stream
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 1);
    configure(8'b1111_1011, 5, 0);
    sendBits("1101101111011");
    idle(1);
    checkOutput("nonoverlap_cnt", 32'(match_cnt), 32'd2);

    // Valid gaps between pattern bits
    applyStimulus(0, 0, '0, 0, 0, 0, 0, 1);
    configure(8'b0001_1011, 5, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, '0, 0, 0, 1, (i != 2), 0);
      for (int g = 0; g < 3; g++) applyStimulus(0, 0, '0, 0, 0, 0, $urandom_range(0, 1), 0);
    end
    checkOutput("gap_cnt", 32'(match_cnt), 32'd1);

    // Illegal lengths from reset
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'hFF, 1, 1, 1, 1, 0);
    idle(1);
    checkOutput("err_len1", 32'(cfg_err), 32'd1);
    idle(1);
    checkOutput("err_pulse_end", 32'(cfg_err), 32'd0);
    applyStimulus(0, 1, 8'hFF, MAX_LEN + 1, 1, 0, 0, 0);
    idle(1);
    checkOutput("err_lenmax1", 32'(cfg_err), 32'd1);
    sendBits("11111111");
    idle(1);
    checkOutput("illegal_armed", 32'(armed), 32'd0);
    checkOutput("illegal_cnt", 32'(match_cnt), 32'd0);

    // Counter saturation, then clear colliding with a match
    configure(8'b0000_0011, 2, 1);
    sendBits("1111111111");
    idle(1);
    checkOutput("sat_cnt", 32'(match_cnt), 32'((1 << CNT_W) - 1));
    applyStimulus(0, 0, '0, 0, 0, 1, 1, 1);
    idle(1);
    checkOutput("clr_priority", 32'(match_cnt), 32'd0);

    // Reset in the middle of a pattern
    configure(8'b0001_1011, 5, 1);
    sendBits("1101");
    applyStimulus(1, 0, '0, 0, 0, 0, 0, 0);
    configure(8'b0001_1011, 5, 1);
    sendBits("1");
    idle(1);
    checkOutput("midrst_nomatch", 32'(match_cnt), 32'd0);
    sendBits("11011");
    idle(1);
    checkOutput("midrst_rematch", 32'(match_cnt), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0)
        applyStimulus(1, 0, '0, 0, 0, 0, 0, 0);
      else if (r < 8)
        applyStimulus(0, 1, MAX_LEN'($urandom), $urandom_range(0, 12), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1), 0);
      else if (r < 14)
        applyStimulus(0, 1, MAX_LEN'($urandom), $urandom_range(2, 3), $urandom_range(0, 1),
                      0, 0, 0);
      else
        applyStimulus(0, 0, '0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                      $urandom_range(0, 40) == 0);
    end

    idle(2);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
